video_frame_tracker: RTL

// Upstream stage of the blurring filter. Takes a 320x240 RGB444 streaming-video packet stream and re-times it

---
 rtl/video_frame_tracker.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/video_frame_tracker.sv
// Frame tracker ahead of the blur filter: one-stage re-timing of an SOP/EOP pixel stream,
// with pixel coordinates, frame-framing repair, per-frame blur level latch and statistics.
module video_frame_tracker #(
    parameter int unsigned IMG_WIDTH  = 320,
    parameter int unsigned IMG_HEIGHT = 240,
    parameter int unsigned DATA_W     = 12,
    parameter int unsigned CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_in,
    output logic              ready_out,
    input  logic              startofpacket_in,
    input  logic              endofpacket_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic [2:0]        freq_flag_in,
    output logic              valid_out,
    input  logic              ready_in,
    output logic              startofpacket_out,
    output logic              endofpacket_out,
    output logic [DATA_W-1:0] data_out,
    output logic [8:0]        x_out,
    output logic [7:0]        y_out,
    output logic [2:0]        freq_flag_out,
    output logic [CNT_W-1:0]  frame_count,
    output logic [CNT_W-1:0]  err_count
);

    localparam int unsigned    X_W      = 9;
    localparam int unsigned    Y_W      = 8;
    localparam logic [X_W-1:0] LAST_X   = X_W'(IMG_WIDTH - 1);
    localparam logic [Y_W-1:0] LAST_Y   = Y_W'(IMG_HEIGHT - 1);
    localparam logic [2:0]     FREQ_MAX = 3'd2;

    // IDLE: silent drop (reset or after a short frame); DONE: a full frame just ended,
    // the first non-SOP beat marks a long frame; DRAIN: silent drop after that.
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_DONE   = 2'd2,
        S_DRAIN  = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nx;

    logic              r_valid;
    logic              r_sop;
    logic              r_eop;
    logic [DATA_W-1:0] r_data;
    logic [X_W-1:0]    r_x_out;
    logic [Y_W-1:0]    r_y_out;
    logic [2:0]        r_freq;
    logic [CNT_W-1:0]  r_frames;
    logic [CNT_W-1:0]  r_err;
    logic [X_W-1:0]    r_x;
    logic [Y_W-1:0]    r_y;

    logic              w_ready;
    logic              w_accept;
    logic              w_fwd;
    logic              w_sop;
    logic              w_eop;
    logic              w_latch;
    logic              w_frame_inc;
    logic [1:0]        w_err_inc;
    logic [X_W-1:0]    w_pos_x;
    logic [Y_W-1:0]    w_pos_y;
    logic [X_W-1:0]    w_nx_x;
    logic [Y_W-1:0]    w_nx_y;
    logic [CNT_W:0]    w_err_sum;
    logic [CNT_W-1:0]  w_err_nx;

    assign w_ready   = !r_valid || ready_in;
    assign w_accept  = valid_in && w_ready;
    assign ready_out = w_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Per-beat decision: forward or drop, pixel position, framing repair and error accounting.
    always_comb begin
        w_state_nx  = r_state;
        w_fwd       = 1'b0;
        w_sop       = 1'b0;
        w_eop       = 1'b0;
        w_latch     = 1'b0;
        w_frame_inc = 1'b0;
        w_err_inc   = 2'd0;
        w_pos_x     = r_x;
        w_pos_y     = r_y;
        w_nx_x      = r_x;
        w_nx_y      = r_y;

        if (w_accept) begin
            case (r_state)
                S_ACTIVE: begin
                    w_fwd = 1'b1;
                    if (startofpacket_in) begin
                        w_sop     = 1'b1;
                        w_latch   = 1'b1;
                        w_pos_x   = '0;
                        w_pos_y   = '0;
                        w_err_inc = 2'd1;
                    end
                end
                S_IDLE, S_DONE, S_DRAIN: begin
                    if (startofpacket_in) begin
                        w_fwd   = 1'b1;
                        w_sop   = 1'b1;
                        w_latch = 1'b1;
                        w_pos_x = '0;
                        w_pos_y = '0;
                    end else if (r_state == S_DONE) begin
                        w_err_inc  = 2'd1;
                        w_state_nx = S_DRAIN;
                    end
                end
                default: w_state_nx = S_IDLE;
            endcase

            // A forwarded beat closes the frame on the last pixel or on an upstream EOP.
            if (w_fwd) begin
                if (w_pos_x == LAST_X && w_pos_y == LAST_Y) begin
                    w_eop       = 1'b1;
                    w_frame_inc = 1'b1;
                    w_state_nx  = S_DONE;
                    w_nx_x      = '0;
                    w_nx_y      = '0;
                end else if (endofpacket_in) begin
                    w_eop      = 1'b1;
                    w_err_inc  = w_err_inc + 2'd1;
                    w_state_nx = S_IDLE;
                    w_nx_x     = '0;
                    w_nx_y     = '0;
                end else begin
                    w_state_nx = S_ACTIVE;
                    if (w_pos_x == LAST_X) begin
                        w_nx_x = '0;
                        w_nx_y = w_pos_y + Y_W'(1);
                    end else begin
                        w_nx_x = w_pos_x + X_W'(1);
                        w_nx_y = w_pos_y;
                    end
                end
            end
        end
    end

    assign w_err_sum = {1'b0, r_err} + (CNT_W+1)'(w_err_inc);
    assign w_err_nx  = w_err_sum[CNT_W] ? '1 : w_err_sum[CNT_W-1:0];

    // Output stage holds its beat until the consumer takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid  <= 1'b0;
            r_sop    <= 1'b0;
            r_eop    <= 1'b0;
            r_data   <= '0;
            r_x_out  <= '0;
            r_y_out  <= '0;
            r_freq   <= 3'd0;
            r_frames <= '0;
            r_err    <= '0;
            r_x      <= '0;
            r_y      <= '0;
        end else begin
            if (w_fwd) begin
                r_valid <= 1'b1;
                r_sop   <= w_sop;
                r_eop   <= w_eop;
                r_data  <= data_in;
                r_x_out <= w_pos_x;
                r_y_out <= w_pos_y;
                r_x     <= w_nx_x;
                r_y     <= w_nx_y;
            end else if (ready_in) begin
                r_valid <= 1'b0;
            end
            if (w_latch) begin
                r_freq <= (freq_flag_in <= FREQ_MAX) ? freq_flag_in : 3'd0;
            end
            if (w_frame_inc) begin
                r_frames <= r_frames + CNT_W'(1);
            end
            r_err <= w_err_nx;
        end
    end

    assign valid_out         = r_valid;
    assign startofpacket_out = r_sop;
    assign endofpacket_out   = r_eop;
    assign data_out          = r_data;
    assign x_out             = r_x_out;
    assign y_out             = r_y_out;
    assign freq_flag_out     = r_freq;
    assign frame_count       = r_frames;
    assign err_count         = r_err;

endmodule
